// File: rtl/x87_pkg.sv
// Command encodings and widths shared by x87_decode, x87_issue_queue and x87_exec.
// Every block refers to commands by name so that all three stay in sync.
package x87_pkg;

  localparam int X87_CW = 5;
  localparam int X87_IW = 3;

  localparam logic [X87_CW-1:0] CMD_NOP       = 5'd0;
  localparam logic [X87_CW-1:0] CMD_FNSTSW_AX = 5'd1;
  localparam logic [X87_CW-1:0] CMD_FNINIT    = 5'd2;
  localparam logic [X87_CW-1:0] CMD_FNCLEX    = 5'd3;
  localparam logic [X87_CW-1:0] CMD_FLDCW     = 5'd4;
  localparam logic [X87_CW-1:0] CMD_FWAIT     = 5'd5;
  localparam logic [X87_CW-1:0] CMD_FLD       = 5'd6;
  localparam logic [X87_CW-1:0] CMD_FST       = 5'd7;
  localparam logic [X87_CW-1:0] CMD_FSTP      = 5'd8;
  localparam logic [X87_CW-1:0] CMD_FXCH      = 5'd9;
  localparam logic [X87_CW-1:0] CMD_FADD      = 5'd20;
  localparam logic [X87_CW-1:0] CMD_FMUL      = 5'd21;
  localparam logic [X87_CW-1:0] CMD_MISC      = 5'd31;

  typedef struct packed {
    logic [X87_CW-1:0] cmd;
    logic [X87_IW-1:0] idx;
  } x87_uop_t;

  function automatic logic is_fwait(input logic [X87_CW-1:0] cmd);
    return cmd == CMD_FWAIT;
  endfunction

endpackage

// File: rtl/x87_cmd_fifo.sv
// Generic synchronous FIFO with registered occupancy; no fall-through, the head
// is read straight from storage at the read pointer.
module x87_cmd_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [W-1:0]    wdata_i,
  output logic [W-1:0]    rdata_o,
  output logic [CNTW-1:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;
  logic            push_ok, pop_ok;

  assign full_o  = (count_q == CNTW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Storage is cleared only by rst so the idle head reads as a NOP; clr just empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) count_q <= CNTW'(DEPTH));

endmodule

// File: rtl/x87_issue_queue.sv
// In-order issue queue between the x87 decoder and x87_exec. FWAIT is resolved
// here (retired once exec is idle) and never offered to exec.
module x87_issue_queue
  import x87_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int CW    = X87_CW,
  parameter  int IW    = X87_IW,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  input  logic            dec_valid,
  input  logic [CW-1:0]   dec_cmd,
  input  logic [IW-1:0]   dec_idx,
  output logic            in_ready,
  output logic            ex_valid,
  output logic [CW-1:0]   ex_cmd,
  output logic [IW-1:0]   ex_idx,
  input  logic            ex_ready,
  input  logic            ex_idle,
  output logic            fwait_done,
  output logic            ud_pulse,
  output logic [CNTW-1:0] count
);

  logic [CW+IW-1:0] head;
  logic             full, empty;
  logic             head_fwait, fwait_retire, accept, push, pop;
  logic             fwait_done_q, fwait_done_d;
  logic             ud_pulse_q, ud_pulse_d;

  x87_cmd_fifo #(.DEPTH(DEPTH), .W(CW + IW)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clr     (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({dec_cmd, dec_idx}),
    .rdata_o (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

  assign {ex_cmd, ex_idx} = head;
  assign head_fwait   = ~empty & (ex_cmd == CW'(CMD_FWAIT));
  assign ex_valid     = ~empty & ~head_fwait;
  assign in_ready     = ~full;
  assign accept       = in_valid & in_ready;
  assign fwait_retire = head_fwait & ex_idle;

  // Flush suppresses every queue side effect of the cycle, including both pulses.
  assign push         = accept & dec_valid & ~flush;
  assign pop          = ((ex_valid & ex_ready) | fwait_retire) & ~flush;
  assign ud_pulse_d   = accept & ~dec_valid & ~flush;
  assign fwait_done_d = fwait_retire & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fwait_done_q <= 1'b0;
      ud_pulse_q   <= 1'b0;
    end else begin
      fwait_done_q <= fwait_done_d;
      ud_pulse_q   <= ud_pulse_d;
    end
  end

  assign fwait_done = fwait_done_q;
  assign ud_pulse   = ud_pulse_q;

endmodule
